// File: rtl/decodificador_eventos_teclado.sv
// -----------------------------------------------------------------------------
// decodificador_eventos_teclado
// Turns raw PS/2 scan-code bytes into 10-bit key events {extended, break, code}
// and queues them in a first-word-fall-through FIFO of 2^W entries. Events that
// arrive while the FIFO is full are dropped and flagged in a sticky overflow bit.
// A prefix (E0 / F0 / E0 F0) that waits TIMEOUT_CYC cycles for its next byte is
// abandoned without producing an event (TIMEOUT_CYC = 0 disables this).
//
// Optional build macro: REPEAT_FILTER_EN
//   When defined, a make event identical to the last accepted make (typematic
//   repeat) is discarded until a matching break is seen.
// -----------------------------------------------------------------------------
module decodificador_eventos_teclado #(
    parameter int W           = 2,
    parameter int TW          = 20,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_done_tick,
    input  logic [7:0]   rx_data,
    input  logic         rd,
    input  logic         ovf_clr,
    output logic [7:0]   ev_code,
    output logic         ev_break,
    output logic         ev_extended,
    output logic         ev_empty,
    output logic         ev_full,
    output logic [W:0]   ev_count,
    output logic         overflow
);

    localparam int            DEPTH     = 1 << W;
    localparam logic [W:0]    DEPTH_CNT = (W+1)'(DEPTH);
    localparam logic [W:0]    CNT_ZERO  = (W+1)'(0);
    localparam logic [W:0]    CNT_ONE   = (W+1)'(1);
    localparam logic [W-1:0]  PTR_ONE   = W'(1);
    localparam logic [TW-1:0] TO_ZERO   = TW'(0);
    localparam logic [TW-1:0] TO_ONE    = TW'(1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic          TO_EN     = (TIMEOUT_CYC != 0);
    localparam logic [7:0]    B_E0      = 8'hE0;
    localparam logic [7:0]    B_F0      = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            timeout_s;
    logic            dec_push_s, dec_ext_s, dec_brk_s;
    logic            push_s;
    logic [9:0]      new_ev_s;

    // The counter value TO_LAST is the last cycle a prefix may still accept a byte.
    assign timeout_s = TO_EN && (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);
    assign new_ev_s  = {dec_ext_s, dec_brk_s, rx_data};

    // Prefix decoder: next state and the event produced by the current byte.
    always_comb begin
        state_d    = state_q;
        dec_push_s = 1'b0;
        dec_ext_s  = 1'b0;
        dec_brk_s  = 1'b0;
        if (rx_done_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == B_E0) begin
                        state_d = ST_E0;
                    end else if (rx_data == B_F0) begin
                        state_d = ST_F0;
                    end else begin
                        dec_push_s = 1'b1;
                    end
                end
                ST_E0: begin
                    if (rx_data == B_F0) begin
                        state_d = ST_E0F0;
                    end else if (rx_data == B_E0) begin
                        state_d = ST_E0;
                    end else begin
                        dec_push_s = 1'b1;
                        dec_ext_s  = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_F0: begin
                    if (rx_data == B_F0) begin
                        state_d = ST_F0;
                    end else if (rx_data == B_E0) begin
                        state_d = ST_E0F0;
                    end else begin
                        dec_push_s = 1'b1;
                        dec_brk_s  = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_E0F0: begin
                    if ((rx_data == B_E0) || (rx_data == B_F0)) begin
                        state_d = ST_E0F0;
                    end else begin
                        dec_push_s = 1'b1;
                        dec_ext_s  = 1'b1;
                        dec_brk_s  = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timeout_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Prefix age: restarts on every byte and stays at zero while idle.
    always_comb begin
        if (rx_done_tick || (state_q == ST_IDLE)) begin
            to_cnt_d = TO_ZERO;
        end else begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end
    end

    // Decoder state and prefix age registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= TO_ZERO;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

`ifdef REPEAT_FILTER_EN
    logic [8:0] last_make_q, last_make_d;
    logic       last_vld_q, last_vld_d;
    logic       rpt_hit_s;

    assign rpt_hit_s = last_vld_q && (last_make_q == {dec_ext_s, rx_data});

    // Typematic filter: suppress a make identical to the last one until its break.
    always_comb begin
        push_s      = dec_push_s;
        last_make_d = last_make_q;
        last_vld_d  = last_vld_q;
        if (dec_push_s && !dec_brk_s) begin
            if (rpt_hit_s) begin
                push_s = 1'b0;
            end else begin
                last_make_d = {dec_ext_s, rx_data};
                last_vld_d  = 1'b1;
            end
        end else if (dec_push_s && rpt_hit_s) begin
            last_vld_d = 1'b0;
        end else begin
            last_vld_d = last_vld_q;
        end
    end

    // Last accepted make register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_make_q <= 9'h000;
            last_vld_q  <= 1'b0;
        end else begin
            last_make_q <= last_make_d;
            last_vld_q  <= last_vld_d;
        end
    end
`else
    assign push_s = dec_push_s;
`endif

    logic [9:0]   mem_q [DEPTH];
    logic [W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W:0]   count_q, count_d;
    logic [9:0]   head_q, head_d;
    logic         empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
    logic         pop_s, wr_s, drop_s;

    // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        pop_s    = rd && (count_q != CNT_ZERO);
        wr_s     = push_s && ((count_q != DEPTH_CNT) || pop_s);
        drop_s   = push_s && (count_q == DEPTH_CNT) && !pop_s;
        wr_ptr_d = wr_s  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        // The new head bypasses memory when it is the entry being written now.
        if (count_d == CNT_ZERO) begin
            head_d = 10'h000;
        end else if (wr_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = new_ev_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        empty_d = (count_d == CNT_ZERO);
        full_d  = (count_d == DEPTH_CNT);
    end

    // Event storage (contents need no reset; validity comes from the count).
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= new_ev_s;
        end
    end

    // FIFO pointers, status flags and registered head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= CNT_ZERO;
            head_q   <= 10'h000;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ev_code     = head_q[7:0];
    assign ev_break    = head_q[8];
    assign ev_extended = head_q[9];
    assign ev_empty    = empty_q;
    assign ev_full     = full_q;
    assign ev_count    = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_decodificador_eventos_teclado.sv
// Bench for decodificador_eventos_teclado (W=2, TIMEOUT_CYC=100): directed
// byte streams, a queue-based event model compared every cycle, and literal
// expectations for the documented scenarios.
module tb_decodificador_eventos_teclado;

    localparam int DEPTH = 4;
    localparam int TO    = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] ev_code;
    logic       ev_break, ev_extended, ev_empty, ev_full, overflow;
    logic [2:0] ev_count;

    int total = 0;
    int bad   = 0;

    decodificador_eventos_teclado #(.W(2), .TW(20), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .rd(rd), .ovf_clr(ovf_clr), .ev_code(ev_code), .ev_break(ev_break),
        .ev_extended(ev_extended), .ev_empty(ev_empty), .ev_full(ev_full),
        .ev_count(ev_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: prefix flags, prefix age, event queue {ext,brk,code}, sticky overflow.
    logic [9:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    int         m_age = 0;
`ifdef REPEAT_FILTER_EN
    logic [8:0] m_last = 9'h000;
    logic       m_last_vld = 1'b0;
`endif

    always @(posedge clk or posedge reset) begin
        logic       do_pop, have_ev, drop;
        logic [9:0] ev;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_age = 0;
`ifdef REPEAT_FILTER_EN
            m_last = 9'h000; m_last_vld = 1'b0;
`endif
        end else begin
            have_ev = 1'b0;
            ev      = 10'h000;
            do_pop  = rd && (mq.size() > 0);
            if (rx_done_tick) begin
                m_age = 0;
                if (rx_data == 8'hE0) m_ext = 1'b1;
                else if (rx_data == 8'hF0) m_brk = 1'b1;
                else begin
                    ev = {m_ext, m_brk, rx_data};
                    have_ev = 1'b1;
                    m_ext = 1'b0; m_brk = 1'b0;
                end
            end else if (m_ext || m_brk) begin
                m_age++;
                if (m_age == TO) begin
                    m_ext = 1'b0; m_brk = 1'b0; m_age = 0;
                end
            end
`ifdef REPEAT_FILTER_EN
            if (have_ev) begin
                if (!ev[8]) begin
                    if (m_last_vld && m_last == {ev[9], ev[7:0]}) have_ev = 1'b0;
                    else begin m_last = {ev[9], ev[7:0]}; m_last_vld = 1'b1; end
                end else if (m_last_vld && m_last == {ev[9], ev[7:0]}) begin
                    m_last_vld = 1'b0;
                end
            end
`endif
            drop = have_ev && (mq.size() == DEPTH) && !do_pop;
            if (do_pop) void'(mq.pop_front());
            if (have_ev && !drop) mq.push_back(ev);
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [15:0] got, exp;
        logic [9:0]  mhead;
        mhead = (mq.size() > 0) ? mq[0] : 10'h000;
        got = {ev_empty, ev_full, ev_count, overflow,
               (ev_empty ? 10'h000 : {ev_extended, ev_break, ev_code})};
        exp = {(mq.size() == 0), (mq.size() == DEPTH), 3'(mq.size()), m_ovf, mhead};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, got, exp);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        #1;
        rx_done_tick = t; rx_data = d; rd = r; ovf_clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic pop_expect(input string nm, input logic [9:0] exp);
        chk(nm, {ev_extended, ev_break, ev_code}, exp);
        chk({nm, "_nonempty"}, ev_empty, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
    endtask

    initial begin
        logic [7:0] bytes6 [6];
        bytes6 = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_empty", ev_empty, 1'b1);
        chk("rst_full", ev_full, 1'b0);
        chk("rst_count", ev_count, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_head", {ev_extended, ev_break, ev_code}, 10'h000);
        #1 reset = 1'b0;
        idle(2);

        // Make, break, extended make, extended break
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(1);
        chk("seq_count", ev_count, 3'd4);
        chk("seq_full", ev_full, 1'b1);
        pop_expect("seq_ev0", 10'h01C);
        pop_expect("seq_ev1", 10'h11C);
        pop_expect("seq_ev2", 10'h275);
        pop_expect("seq_ev3", 10'h375);
        chk("seq_empty", ev_empty, 1'b1);

        // Overflow: five makes into four slots
        send(8'h15); send(8'h16); send(8'h17); send(8'h18); send(8'h19);
        idle(1);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", ev_count, 3'd4);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);
        chk("ovf_clr", overflow, 1'b0);
        pop_expect("ovf_ev0", 10'h015);
        pop_expect("ovf_ev1", 10'h016);
        pop_expect("ovf_ev2", 10'h017);
        pop_expect("ovf_ev3", 10'h018);
        chk("ovf_empty", ev_empty, 1'b1);

        // Full FIFO: push and pop in the same cycle
        send(8'h21); send(8'h22); send(8'h23); send(8'h24);
        cyc(1'b1, 8'h2A, 1'b1, 1'b0);
        idle(1);
        chk("fullrw_count", ev_count, 3'd4);
        chk("fullrw_ovf", overflow, 1'b0);
        pop_expect("fullrw_ev0", 10'h022);
        pop_expect("fullrw_ev1", 10'h023);
        pop_expect("fullrw_ev2", 10'h024);
        pop_expect("fullrw_ev3", 10'h02A);

        // Empty FIFO: rd ignored, simultaneous push written
        cyc(1'b1, 8'h33, 1'b1, 1'b0);
        idle(1);
        chk("emptyrw_count", ev_count, 3'd1);
        pop_expect("emptyrw_ev", 10'h033);

        // Prefix timeout: 100 idle cycles discard E0, 99 do not
        send(8'hE0); idle(TO); send(8'h1C); idle(1);
        pop_expect("to_expired", 10'h01C);
        send(8'hE0); idle(TO - 1); send(8'h1C); idle(1);
        pop_expect("to_kept", 10'h21C);

        // Reset while a break prefix is pending with two events queued
        send(8'h11); send(8'h12); send(8'hF0); idle(1);
        chk("mrst_pre_count", ev_count, 3'd2);
        @(negedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_empty", ev_empty, 1'b1);
        chk("mrst_ovf", overflow, 1'b0);
        #1 reset = 1'b0;
        send(8'h1C); idle(1);
        chk("mrst_count", ev_count, 3'd1);
        pop_expect("mrst_make", 10'h01C);

        // Typematic repeats
        for (int i = 0; i < 6; i++) send(bytes6[i]);
        idle(1);
`ifdef REPEAT_FILTER_EN
        chk("rpt_count", ev_count, 3'd3);
        pop_expect("rpt_ev0", 10'h01C);
        pop_expect("rpt_ev1", 10'h11C);
        pop_expect("rpt_ev2", 10'h01C);
`else
        chk("rpt_count", ev_count, 3'd4);
        chk("rpt_ovf", overflow, 1'b1);
        pop_expect("rpt_ev0", 10'h01C);
        pop_expect("rpt_ev1", 10'h01C);
        pop_expect("rpt_ev2", 10'h01C);
        pop_expect("rpt_ev3", 10'h11C);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);
`endif
        chk("rpt_empty", ev_empty, 1'b1);

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
